// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Multicycle CPU control sequencer. Steps each instruction through
//             IF/ID/EXE/MEM/WB and, in the last cycle of each instruction,
//             presents the next-PC select (PCSrc) with a one-cycle PCWre
//             pulse. IRWre loads the instruction register in IF.
//  Options  : PCSEQ_ILLEGAL_TRAP_EN - when defined, an unknown opcode traps
//             into HALT with Illegal=1. When undefined, an unknown opcode
//             retires as a 2-cycle NOP and Illegal is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int OP_W = 6
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [OP_W-1:0] Opcode,
  input  logic            Zero,
  input  logic            Sign,
  output logic [1:0]      PCSrc,
  output logic            PCWre,
  output logic            IRWre,
  output logic [2:0]      State,
  output logic            Halted,
  output logic            Illegal
);

  // --------------------------------------------------------------------------
  // Opcode map
  // --------------------------------------------------------------------------
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b000110);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110101);
  localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(6'b110110);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

  // Next-PC select codes
  localparam logic [1:0] SRC_PC4  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_RS   = 2'b10;
  localparam logic [1:0] SRC_JUMP = 2'b11;

  // --------------------------------------------------------------------------
  // State encoding (visible on the State debug port)
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_EXE_MEM = 3'b010,
    S_MEM     = 3'b011,
    S_WB_LW   = 3'b100,
    S_EXE_BR  = 3'b101,
    S_EXE_R   = 3'b110,
    S_WB_R    = 3'b111
  } state_t;

  // Instruction class derived from the opcode; drives the ID fan-out.
  typedef enum logic [2:0] {
    CL_ALU  = 3'd0,
    CL_BR   = 3'd1,
    CL_MEM  = 3'd2,
    CL_JMP  = 3'd3,
    CL_HALT = 3'd4,
    CL_BAD  = 3'd5
  } op_class_t;

  state_t    state_q, state_d;
  logic      halted_q, halted_d;
  op_class_t op_class;
  logic      br_taken;
  logic      pc_wre_raw;
  logic [1:0] pc_src_raw;
  logic      ir_wre_raw;
  logic      trap_now;

  // Classify the current opcode into the groups the sequencer cares about
  always_comb begin
    op_class = CL_BAD;
    case (Opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
      OP_ORI, OP_SLL, OP_SLT, OP_SLTI:  op_class = CL_ALU;
      OP_BEQ, OP_BNE, OP_BLTZ:          op_class = CL_BR;
      OP_SW, OP_LW:                     op_class = CL_MEM;
      OP_J, OP_JR, OP_JAL:              op_class = CL_JMP;
      OP_HALT:                          op_class = CL_HALT;
      default:                          op_class = CL_BAD;
    endcase
  end

  // Branch condition; the flags only matter when the FSM is in EXE_BR
  always_comb begin
    br_taken = 1'b0;
    case (Opcode)
      OP_BEQ:  br_taken = Zero;
      OP_BNE:  br_taken = ~Zero;
      OP_BLTZ: br_taken = Sign;
      default: br_taken = 1'b0;
    endcase
  end

  // State register and sticky halt flag; the halt flag is cleared only by reset
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

`ifdef PCSEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Remembers that HALT was entered through an unknown opcode
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      illegal_q <= 1'b0;
    end else if (trap_now) begin
      illegal_q <= 1'b1;
    end
  end

  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  // Next-state and raw output decode; everything defaults to idle first
  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    pc_wre_raw = 1'b0;
    pc_src_raw = SRC_PC4;
    ir_wre_raw = 1'b0;
    trap_now   = 1'b0;

    if (!halted_q) begin
      case (state_q)
        S_IF: begin
          ir_wre_raw = 1'b1;
          state_d    = S_ID;
        end

        S_ID: begin
          case (op_class)
            CL_ALU:  state_d = S_EXE_R;
            CL_BR:   state_d = S_EXE_BR;
            CL_MEM:  state_d = S_EXE_MEM;
            CL_JMP: begin
              // Jumps retire straight out of decode
              pc_wre_raw = 1'b1;
              pc_src_raw = (Opcode == OP_JR) ? SRC_RS : SRC_JUMP;
              state_d    = S_IF;
            end
            CL_HALT: begin
              // HALT shows as ID on the State port, frozen by the sticky flag
              halted_d = 1'b1;
              state_d  = S_ID;
            end
            default: begin
`ifdef PCSEQ_ILLEGAL_TRAP_EN
              halted_d = 1'b1;
              trap_now = 1'b1;
              state_d  = S_ID;
`else
              // Unknown opcode retires as a NOP: advance to PC+4
              pc_wre_raw = 1'b1;
              pc_src_raw = SRC_PC4;
              state_d    = S_IF;
`endif
            end
          endcase
        end

        S_EXE_R: state_d = S_WB_R;

        S_WB_R: begin
          pc_wre_raw = 1'b1;
          state_d    = S_IF;
        end

        S_EXE_BR: begin
          pc_wre_raw = 1'b1;
          pc_src_raw = br_taken ? SRC_BR : SRC_PC4;
          state_d    = S_IF;
        end

        S_EXE_MEM: state_d = S_MEM;

        S_MEM: begin
          // A store is finished once memory is written; a load needs write-back
          if (Opcode == OP_SW) begin
            pc_wre_raw = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_WB_LW;
          end
        end

        S_WB_LW: begin
          pc_wre_raw = 1'b1;
          state_d    = S_IF;
        end

        default: state_d = S_IF;
      endcase
    end
  end

  // Reset low suppresses every strobe in the cycle it is applied, so an
  // aborted instruction never updates the PC or IR.
  assign PCWre  = pc_wre_raw & Reset;
  assign PCSrc  = (pc_wre_raw & Reset) ? pc_src_raw : SRC_PC4;
  assign IRWre  = ir_wre_raw & Reset;
  assign State  = state_q;
  assign Halted = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed, table-driven bench for pc_sequencer, plus hand-written
//             sequences for halt, reset abort and unknown-opcode handling.
//             Honours PCSEQ_ILLEGAL_TRAP_EN for the unknown-opcode case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic [1:0] pc_src;
  logic       pc_wre;
  logic       ir_wre;
  logic [2:0] state;
  logic       halted;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.OP_W(6)) dut (
    .CLK     (clk),
    .Reset   (rst_n),
    .Opcode  (opcode),
    .Zero    (zero),
    .Sign    (sign),
    .PCSrc   (pc_src),
    .PCWre   (pc_wre),
    .IRWre   (ir_wre),
    .State   (state),
    .Halted  (halted),
    .Illegal (illegal)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One instruction: state sequence packed low-slot-first, 3 bits per cycle
  typedef struct {
    string      name;
    logic [5:0] op;
    logic       z;
    logic       s;
    int         len;
    logic [14:0] seq;
    logic [1:0] src;
  } vec_t;

  vec_t vecs[$];

  // Runs one instruction starting at a falling edge with the FSM in IF
  task automatic run_vec(input vec_t v);
    logic [2:0] exp_st;
    opcode = v.op;
    zero   = v.z;
    sign   = v.s;
    for (int i = 0; i < v.len; i++) begin
      #1;
      exp_st = v.seq[3*i +: 3];
      chk($sformatf("%s c%0d State", v.name, i), int'(state), int'(exp_st));
      chk($sformatf("%s c%0d IRWre", v.name, i), int'(ir_wre), (i == 0) ? 1 : 0);
      chk($sformatf("%s c%0d PCWre", v.name, i), int'(pc_wre), (i == v.len - 1) ? 1 : 0);
      chk($sformatf("%s c%0d PCSrc", v.name, i), int'(pc_src),
          (i == v.len - 1) ? int'(v.src) : 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;
    sign   = 1'b0;

    // Instruction table: name, opcode, Zero, Sign, cycles, states, PCSrc
    vecs.push_back('{"add",     6'b000000, 1'b0, 1'b0, 4, {3'd0, 3'd7, 3'd6, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"beq_t",   6'b110100, 1'b1, 1'b0, 3, {3'd0, 3'd0, 3'd5, 3'd1, 3'd0}, 2'b01});
    vecs.push_back('{"beq_nt",  6'b110100, 1'b0, 1'b0, 3, {3'd0, 3'd0, 3'd5, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"bne_t",   6'b110101, 1'b0, 1'b0, 3, {3'd0, 3'd0, 3'd5, 3'd1, 3'd0}, 2'b01});
    vecs.push_back('{"bne_nt",  6'b110101, 1'b1, 1'b1, 3, {3'd0, 3'd0, 3'd5, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"bltz_t",  6'b110110, 1'b0, 1'b1, 3, {3'd0, 3'd0, 3'd5, 3'd1, 3'd0}, 2'b01});
    vecs.push_back('{"bltz_nt", 6'b110110, 1'b1, 1'b0, 3, {3'd0, 3'd0, 3'd5, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"lw",      6'b110001, 1'b0, 1'b0, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"sw",      6'b110000, 1'b1, 1'b1, 4, {3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"j",       6'b111000, 1'b0, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 2'b11});
    vecs.push_back('{"jr",      6'b111001, 1'b0, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 2'b10});
    vecs.push_back('{"jal",     6'b111010, 1'b0, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 2'b11});
    vecs.push_back('{"slti",    6'b100111, 1'b1, 1'b0, 4, {3'd0, 3'd7, 3'd6, 3'd1, 3'd0}, 2'b00});
    vecs.push_back('{"sll",     6'b000110, 1'b0, 1'b1, 4, {3'd0, 3'd7, 3'd6, 3'd1, 3'd0}, 2'b00});
`ifndef PCSEQ_ILLEGAL_TRAP_EN
    vecs.push_back('{"unk_nop", 6'b010101, 1'b0, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 2'b00});
`endif
    vecs.push_back('{"add2",    6'b000000, 1'b1, 1'b1, 4, {3'd0, 3'd7, 3'd6, 3'd1, 3'd0}, 2'b00});

    // Reset held low: everything idle, IRWre forced low
    @(negedge clk);
    @(negedge clk);
    chk("rst State",   int'(state),   0);
    chk("rst IRWre",   int'(ir_wre),  0);
    chk("rst PCWre",   int'(pc_wre),  0);
    chk("rst PCSrc",   int'(pc_src),  0);
    chk("rst Halted",  int'(halted),  0);
    chk("rst Illegal", int'(illegal), 0);

    // Release reset; the first IF cycle begins here
    rst_n = 1'b1;
    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset asserted in EXE_R aborts the add without a PC write
    opcode = 6'b000000;
    @(negedge clk);                     // now ID
    @(negedge clk);                     // now EXE_R
    #1 chk("abortR State", int'(state), 6);
    rst_n = 1'b0;
    #1 chk("abortR PCWre", int'(pc_wre), 0);
    @(negedge clk);
    #1 chk("abortR IF State", int'(state), 0);
    chk("abortR IF PCWre", int'(pc_wre), 0);
    chk("abortR IF IRWre", int'(ir_wre), 0);
    rst_n = 1'b1;

    // Reset asserted in WB_R: the would-be PCWre pulse is suppressed
    @(negedge clk);                     // ID
    @(negedge clk);                     // EXE_R
    @(negedge clk);                     // WB_R
    #1 chk("abortWB State", int'(state), 7);
    rst_n = 1'b0;
    #1 chk("abortWB PCWre", int'(pc_wre), 0);
    chk("abortWB PCSrc", int'(pc_src), 0);
    @(negedge clk);
    #1 chk("abortWB IF State", int'(state), 0);
    rst_n = 1'b1;

    // Branch: flags wiggle outside EXE_BR, final value decides
    opcode = 6'b110100;
    zero   = 1'b1;                      // IF
    @(negedge clk);
    zero   = 1'b1;                      // ID
    @(negedge clk);
    zero   = 1'b0;                      // EXE_BR, not taken
    #1 chk("beqlate State", int'(state), 5);
    chk("beqlate PCWre", int'(pc_wre), 1);
    chk("beqlate PCSrc", int'(pc_src), 0);
    @(negedge clk);

    // halt: IF, ID (no PC write), then sticky HALT
    opcode = 6'b111111;
    #1 chk("halt IF IRWre", int'(ir_wre), 1);
    @(negedge clk);
    #1 chk("halt ID State", int'(state), 1);
    chk("halt ID PCWre", int'(pc_wre), 0);
    @(negedge clk);
    opcode = 6'b000000;                 // opcode changes must not wake it
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("halt h%0d Halted", i), int'(halted), 1);
      chk($sformatf("halt h%0d PCWre", i),  int'(pc_wre), 0);
      chk($sformatf("halt h%0d State", i),  int'(state),  1);
      chk($sformatf("halt h%0d IRWre", i),  int'(ir_wre), 0);
      chk($sformatf("halt h%0d Illegal", i), int'(illegal), 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk("halt rst State",  int'(state),  0);
    chk("halt rst Halted", int'(halted), 0);
    rst_n = 1'b1;
    #1 chk("halt rel IRWre", int'(ir_wre), 1);

    // Unknown opcode 010101
    opcode = 6'b010101;
    @(negedge clk);                     // ID
`ifdef PCSEQ_ILLEGAL_TRAP_EN
    #1 chk("trap ID PCWre", int'(pc_wre), 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("trap t%0d Illegal", i), int'(illegal), 1);
      chk($sformatf("trap t%0d Halted", i),  int'(halted),  1);
      chk($sformatf("trap t%0d PCWre", i),   int'(pc_wre),  0);
      chk($sformatf("trap t%0d State", i),   int'(state),   1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk("trap rst Illegal", int'(illegal), 0);
    chk("trap rst Halted", int'(halted), 0);
    rst_n = 1'b1;
`else
    #1 chk("nop ID PCWre", int'(pc_wre), 1);
    chk("nop ID PCSrc", int'(pc_src), 0);
    chk("nop ID Illegal", int'(illegal), 0);
    @(negedge clk);
    #1 chk("nop IF State", int'(state), 0);
    chk("nop IF Halted", int'(halted), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle control sequencer that drives the PC source select and PC/IR write enables for the multicycle CPU. It steps each instruction through IF/ID/EXE/MEM/WB, and in the final cycle of each instruction it presents the `PCSrc` code consumed by the PC source mux together with a one-cycle `PCWre` pulse. It sits between the instruction register (opcode) and ALU flags on one side, and the PC mux/PC register on the other.

## Interface
Parameters:
- `OP_W`, 6, opcode width.

Ports:
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-low reset.
- `Opcode` input OP_W: opcode from the instruction register; stable from ID to end of instruction.
- `Zero` input 1: ALU result == 0; valid in EXE_BR.
- `Sign` input 1: ALU result bit 31; valid in EXE_BR.
- `PCSrc` output 2: next-PC select. 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs register (jr), 11 = jump target.
- `PCWre` output 1: PC register write enable, one cycle per instruction.
- `IRWre` output 1: instruction register load, asserted in IF.
- `State` output 3: current state, for debug/trace.
- `Halted` output 1: high in HALT.
- `Illegal` output 1: high in HALT when entered via an unknown opcode (macro-dependent).

## Operation
- Opcodes: add 000000, sub 000001, addi 000010, or 000011, and 000100, ori 000101, sll 000110, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- State encoding: IF 000, ID 001, EXE_MEM 010, MEM 011, WB_LW 100, EXE_BR 101, EXE_R 110, WB_R 111. HALT is a separate sticky flag plus `State` = ID.
- Transitions:
  - IF → ID.
  - ID → EXE_R for ALU ops, EXE_BR for beq/bne/bltz, EXE_MEM for sw/lw.
  - ID → IF for j/jr/jal.
  - ID → HALT for halt.
  - EXE_R → WB_R → IF.
  - EXE_BR → IF.
  - EXE_MEM → MEM. MEM → IF for sw, MEM → WB_LW for lw. WB_LW → IF.
  - HALT is left only by reset.
- Outputs are decoded from the state register, registered opcode and flags. They are never registered separately.
- `IRWre` = 1 only in IF.
- `PCWre` = 1 only in the last cycle of an instruction: WB_R, EXE_BR, MEM (sw), WB_LW, and ID (j/jr/jal). It is 0 in every other state and in HALT.
- `PCSrc` when `PCWre` = 1:
  - Branches in EXE_BR use 01 if taken, else 00. Taken means: beq when `Zero`=1; bne when `Zero`=0; bltz when `Sign`=1.
  - j and jal use 11. jr uses 10. All other instructions use 00.
- `PCSrc` = 00 whenever `PCWre` = 0.

## Timing
- Cycles per instruction: ALU 4, branch 3, sw 4, lw 5, j/jr/jal 2. halt reaches HALT after 2 cycles.
- Reset is applied on the `CLK` edge while `Reset` = 0. Reset values:
  - State = IF, `PCWre` = 0, `IRWre` = 0, `PCSrc` = 00, `Halted` = 0, `Illegal` = 0.
  - `IRWre` is forced to 0 while `Reset` = 0.
  - The first IF cycle after `Reset` rises asserts `IRWre` = 1.
- Reset mid-instruction (any state, including HALT) aborts the instruction. No `PCWre` pulse is issued in the reset cycle.
- `Zero`/`Sign` are sampled only in EXE_BR. Changes in other states have no effect.
- `Opcode` changes outside IF are ignored for transitions already taken. The decode uses `Opcode` in ID and in the final cycle.

## Configuration
- `PCSEQ_ILLEGAL_TRAP_EN` defined: an unknown opcode in ID → HALT with `Illegal` = 1 and `Halted` = 1, `PCWre` = 0.
- `PCSEQ_ILLEGAL_TRAP_EN` not defined: an unknown opcode is a 2-cycle NOP. ID → IF with `PCWre` = 1 and `PCSrc` = 00. `Illegal` is tied to 0.

## Test plan
- Reset then add (000000):
  - `State` = 000, 001, 110, 111, 000.
  - `IRWre` = 1 in cycle 0 only.
  - `PCWre` = 1 in cycle 3 with `PCSrc` = 00.
- beq with `Zero` = 1 → 3 cycles, `PCWre` pulse in EXE_BR with `PCSrc` = 01. Repeat with `Zero` = 0 → `PCSrc` = 00. Check bne and bltz (`Sign` = 1 → 01).
- lw 110001 → states IF, ID, EXE_MEM, MEM, WB_LW, with a single `PCWre` in WB_LW. sw 110000 → `PCWre` in MEM, then back to IF.
- j/jr/jal:
  - j → ID with `PCWre` = 1, `PCSrc` = 11.
  - jr → `PCSrc` = 10.
  - jal → `PCSrc` = 11.
  - Next state is IF in each case.
- halt 111111 → `Halted` = 1 and `PCWre` = 0 held for 20 cycles. `Reset` low for one edge → IF, `Halted` = 0.
- Opcode 010101:
  - With `PCSEQ_ILLEGAL_TRAP_EN` defined → `Illegal` = 1 and stuck in HALT.
  - Without it → `PCWre` = 1, `PCSrc` = 00 in ID, then IF.
  - Also assert `Reset` low in EXE_R → no `PCWre`, `State` = IF.
